// File: rtl/cacheline_arbiter.sv
// Round-robin arbiter sharing one cacheline memory port between the I-cache and D-cache miss paths.
// The winning request is latched at grant and held on the memory port until pmem_resp.
module cacheline_arbiter #(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp,
    output logic [1:0]        dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2,
        DONE    = 2'd3
    } state_e;

    localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-5){1'b1}}, 5'b0};

    state_e            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic              write_q, write_d;
    logic              d_req;
    logic              pick_d;

    // On contention D wins exactly when I was served last (last_grant = 0).
    assign d_req       = d_read | d_write;
    assign pick_d      = d_req & (~i_read | ~last_grant_q);
    assign dbg_state_o = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            write_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            write_q      <= write_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        write_d      = write_q;
        i_rdata      = '0;
        i_resp       = 1'b0;
        d_rdata      = '0;
        d_resp       = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;

        case (state_q)
            IDLE: begin
                if (pick_d) begin
                    state_d      = GRANT_D;
                    last_grant_d = 1'b1;
                    addr_d       = d_address & LINE_MASK;
                    wdata_d      = d_wdata;
                    write_d      = d_write;
                end else if (i_read) begin
                    state_d      = GRANT_I;
                    last_grant_d = 1'b0;
                    addr_d       = i_address & LINE_MASK;
                    wdata_d      = '0;
                    write_d      = 1'b0;
                end
            end
            GRANT_I, GRANT_D: begin
                // Memory side sees only latched values, so requester changes mid-grant are invisible.
                pmem_read    = ~write_q;
                pmem_write   = write_q;
                pmem_address = addr_q;
                pmem_wdata   = wdata_q;
                if (pmem_resp) begin
                    state_d = DONE;
                    if (state_q == GRANT_I) begin
                        i_resp  = 1'b1;
                        i_rdata = pmem_rdata;
                    end else begin
                        d_resp  = 1'b1;
                        d_rdata = pmem_rdata;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cacheline_arbiter.sv
// Bench for cacheline_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_cacheline_arbiter;
    localparam int LINE_W = 256;
    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_read;
    logic [ADDR_W-1:0] i_address;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_address;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;
    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;
    logic [1:0]        dbg_state;

    always #5 clk = ~clk;

    cacheline_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .dbg_state_o(dbg_state)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: phase 0 = free, 1 = one transaction owns the port, 2 = one-cycle cooldown.
    int                m_phase;
    bit                m_win;      // 0 = I, 1 = D
    bit                m_last;
    bit                m_write;
    logic [ADDR_W-1:0] m_addr;
    logic [LINE_W-1:0] m_wdata;

    function automatic void model_reset();
        m_phase = 0; m_win = 0; m_last = 0; m_write = 0; m_addr = '0; m_wdata = '0;
    endfunction

    task automatic model_edge();
        bit want_i, want_d;
        want_i = i_read;
        want_d = d_read | d_write;
        if (rst) model_reset();
        else if (m_phase == 2) m_phase = 0;
        else if (m_phase == 1) begin
            if (pmem_resp) m_phase = 2;
        end else if (want_i || want_d) begin
            m_win   = (want_i && want_d) ? !m_last : want_d;
            m_last  = m_win;
            m_phase = 1;
            if (m_win) begin
                m_addr  = {d_address[ADDR_W-1:5], 5'b0};
                m_wdata = d_wdata;
                m_write = d_write;
            end else begin
                m_addr  = {i_address[ADDR_W-1:5], 5'b0};
                m_wdata = '0;
                m_write = 0;
            end
        end
    endtask

    bit   i_seen, d_seen;
    int   i_pulses, d_pulses;
    logic got_q[$];
    logic exp_q[$];

    task automatic check_outputs();
        bit g, ir, dr;
        g  = (m_phase == 1) && !rst;
        ir = g && !m_win && pmem_resp;
        dr = g && m_win && pmem_resp;
        check("pmem_read", pmem_read, g && !m_write);
        check("pmem_write", pmem_write, g && m_write);
        check("pmem_address", pmem_address, g ? m_addr : '0);
        check("pmem_wdata", pmem_wdata, g ? m_wdata : '0);
        check("i_resp", i_resp, ir);
        check("d_resp", d_resp, dr);
        check("i_rdata", i_rdata, ir ? pmem_rdata : '0);
        check("d_rdata", d_rdata, dr ? pmem_rdata : '0);
        i_seen = i_resp;
        d_seen = d_resp;
        if (i_resp) begin i_pulses++; got_q.push_back(1'b0); end
        if (d_resp) begin d_pulses++; got_q.push_back(1'b1); end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic drive_random();
        if (i_read) begin
            if (i_seen) i_read = 0;
        end else if (!i_seen && $urandom_range(0, 2) == 0) begin
            i_read = 1; i_address = $urandom;
        end
        if (d_read || d_write) begin
            if (d_seen) begin
                d_read = 0; d_write = 0;
            end else if (m_phase == 1 && m_win && $urandom_range(0, 9) == 0) begin
                d_read = 0; d_write = 0; d_address = $urandom;
            end
        end else if (!d_seen && $urandom_range(0, 2) == 0) begin
            int op;
            op = $urandom_range(0, 7);
            d_read    = (op < 4);
            d_write   = (op == 0) || (op >= 4);
            d_address = $urandom;
            d_wdata   = {8{$urandom}};
        end
        pmem_rdata = {8{$urandom}};
        pmem_resp  = $urandom_range(0, 99) < ((pmem_read || pmem_write) ? 35 : 10);
    endtask

    task automatic drive_contention();
        if (i_seen) i_read = 0;
        else if (!i_read) begin i_read = 1; i_address = $urandom; end
        if (d_seen) d_write = 0;
        else if (!d_write) begin d_write = 1; d_address = $urandom; d_wdata = {8{$urandom}}; end
        pmem_rdata = {8{$urandom}};
        pmem_resp  = (pmem_read || pmem_write) && ($urandom_range(0, 2) == 0);
    endtask

    initial begin
        int gc;
        rst = 1; i_read = 1; i_address = 32'h0000_1044;
        d_read = 0; d_write = 0; d_address = '0; d_wdata = '0;
        pmem_rdata = '0; pmem_resp = 0;
        model_reset();

        // Reset with i_read held, then release: grant I next edge, then a 5-cycle memory wait.
        repeat (2) sample();
        tick(); rst = 0; sample();
        tick(); sample();
        check("t1_pmem_read", pmem_read, 1'b1);
        check("t1_addr", pmem_address, 32'h0000_1040);
        i_pulses = 0; d_pulses = 0; gc = 1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (i_seen) i_read = 0;
            pmem_resp  = (pmem_read || pmem_write) && (gc == 5);
            pmem_rdata = {32{8'hA5}};
            if (pmem_read || pmem_write) gc++;
            sample();
            if (i_resp) check("t2_rdata", i_rdata, {32{8'hA5}});
        end
        check("t2_i_pulses", i_pulses, 1);
        check("t2_d_pulses", d_pulses, 0);

        // D read whose address and request change mid-grant.
        tick(); pmem_resp = 0; d_read = 1; d_address = 32'h2000_0064; sample();
        tick(); sample();
        check("t5_addr_grant", pmem_address, 32'h2000_0060);
        tick(); d_read = 0; d_address = 32'hFFFF_FFE0; sample();
        check("t5_addr_held", pmem_address, 32'h2000_0060);
        tick(); pmem_resp = 1; pmem_rdata = {8{32'hDEAD_BEEF}}; sample();
        check("t5_d_resp", d_resp, 1'b1);
        tick(); pmem_resp = 0; sample();
        tick(); sample();

        // Async reset mid GRANT_D, then spurious pmem_resp in IDLE.
        tick(); d_write = 1; d_address = 32'h0000_3000; d_wdata = {8{32'h1234_5678}}; sample();
        tick(); sample();
        check("t6_pmem_write", pmem_write, 1'b1);
        #2 rst = 1; model_reset(); #1;
        check_outputs();
        check("t6_async_write", pmem_write, 1'b0);
        tick(); d_write = 0; rst = 0; pmem_resp = 1; sample();
        tick(); sample();
        check("t6_spurious", {i_resp, d_resp}, 2'b00);

        // Continuous contention from reset state: D, I, D, I, D, I.
        tick(); pmem_resp = 0; got_q.delete(); sample();
        exp_q = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int k = 0; k < 300 && got_q.size() < 6; k++) begin
            tick(); drive_contention(); sample();
        end
        check("t4_count", got_q.size() >= 6, 1'b1);
        while (exp_q.size() > 0 && got_q.size() > 0)
            check("t4_order", got_q.pop_front(), exp_q.pop_front());
        tick(); i_read = 0; d_write = 0; pmem_resp = 0; sample();
        repeat (3) begin tick(); sample(); end

        // Random traffic.
        for (int k = 0; k < 2000; k++) begin
            tick(); drive_random(); sample();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
